// File: rtl/uart_regfile.sv
// uart_regfile: UART register file with TX/RX byte FIFOs behind the APB front-end.
// Optional build macro UART_REGFILE_IRQ_EN adds the INT_EN register at 0x010
// and a registered interrupt output; without it 0x010 is unmapped and irq is 0.
module uart_regfile #(
   parameter int unsigned DEPTH    = 16,
   parameter logic [15:0] BAUD_RST = 16'd27
) (
   input  logic        pclk,
   input  logic        prst_n,
   input  logic [11:0] waddr,
   input  logic [31:0] wdata,
   input  logic        wr_en,
   input  logic [11:0] raddr,
   input  logic        rd_en,
   output logic [31:0] rdata,
   output logic        rack,
   output logic        wack,
   output logic        raddrerr,
   output logic        waddrerr,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  cfg_ctrl,
   output logic [15:0] cfg_baud,
   output logic        irq
);

   localparam int unsigned    AW        = $clog2(DEPTH);
   localparam int unsigned    LW        = AW + 1;
   localparam logic [LW-1:0]  FULL_LVL  = LW'(DEPTH);
   localparam logic [LW-1:0]  ZERO_LVL  = LW'(1'b0);
   localparam logic [11:0]    ADDR_DATA   = 12'h000;
   localparam logic [11:0]    ADDR_STATUS = 12'h004;
   localparam logic [11:0]    ADDR_CTRL   = 12'h008;
   localparam logic [11:0]    ADDR_BAUD   = 12'h00C;
`ifdef UART_REGFILE_IRQ_EN
   localparam logic [11:0]    ADDR_INT_EN = 12'h010;
`endif

   // state
   logic          wr_en_q_r;
   logic [7:0]    tx_mem_r [DEPTH];
   logic [7:0]    rx_mem_r [DEPTH];
   logic [AW-1:0] tx_wptr_r, tx_rptr_r, rx_wptr_r, rx_rptr_r;
   logic [LW-1:0] tx_level_r, rx_level_r;
   logic          tx_ovf_r, rx_ovr_r;
   logic [7:0]    ctrl_r;
   logic [15:0]   baud_r;
`ifdef UART_REGFILE_IRQ_EN
   logic [3:0]    int_en_r;
   logic          irq_r;
`endif

   // combinational
   logic          commit_s;
   logic          tx_empty_s, tx_full_s, rx_empty_s, rx_full_s;
   logic          tx_valid_s, tx_pop_s, tx_push_s, tx_ovf_set_s;
   logic          rx_push_req_s, rx_pop_s, rx_push_s, rx_ovr_set_s;
   logic          wr_data_s, wr_status_s, wr_ctrl_s, wr_baud_s, wr_int_en_s, wr_unmapped_s;
   logic          rd_data_s, raddrerr_s;
   logic [31:0]   rdata_s, status_s;
   logic          unused_ok_s;

   assign unused_ok_s = ^{1'b0, wdata[31:16]};

   // A transfer commits only on the first cycle of the two-cycle wr_en pulse.
   assign commit_s   = wr_en & ~wr_en_q_r;

   assign tx_empty_s = (tx_level_r == ZERO_LVL);
   assign tx_full_s  = (tx_level_r == FULL_LVL);
   assign rx_empty_s = (rx_level_r == ZERO_LVL);
   assign rx_full_s  = (rx_level_r == FULL_LVL);

   assign tx_valid_s = ctrl_r[0] & ~tx_empty_s;
   assign tx_pop_s   = tx_valid_s & tx_ready;
   // A full FIFO still takes the byte when the head leaves in the same cycle.
   assign tx_push_s    = wr_data_s & (~tx_full_s | tx_pop_s);
   assign tx_ovf_set_s = wr_data_s & tx_full_s & ~tx_pop_s;

   assign rx_push_req_s = rx_valid & ctrl_r[1];
   assign rx_pop_s      = rd_data_s & ~rx_empty_s;
   assign rx_push_s     = rx_push_req_s & (~rx_full_s | rx_pop_s);
   assign rx_ovr_set_s  = rx_push_req_s & rx_full_s & ~rx_pop_s;

   assign status_s = {8'h00, 8'(rx_level_r), 8'(tx_level_r), 2'b00,
                      tx_ovf_r, rx_ovr_r, rx_empty_s, rx_full_s, tx_empty_s, tx_full_s};

   // Write address decode, qualified by the commit pulse.
   always_comb begin
      wr_data_s     = 1'b0;
      wr_status_s   = 1'b0;
      wr_ctrl_s     = 1'b0;
      wr_baud_s     = 1'b0;
      wr_int_en_s   = 1'b0;
      wr_unmapped_s = 1'b0;
      if (commit_s) begin
         case (waddr)
            ADDR_DATA:   wr_data_s   = 1'b1;
            ADDR_STATUS: wr_status_s = 1'b1;
            ADDR_CTRL:   wr_ctrl_s   = 1'b1;
            ADDR_BAUD:   wr_baud_s   = 1'b1;
`ifdef UART_REGFILE_IRQ_EN
            ADDR_INT_EN: wr_int_en_s = 1'b1;
`endif
            default:     wr_unmapped_s = 1'b1;
         endcase
      end else begin
         wr_unmapped_s = 1'b0;
      end
   end

   // Zero-wait-state read mux; everything reads as zero while rd_en is low.
   always_comb begin
      rdata_s    = 32'h0000_0000;
      raddrerr_s = 1'b0;
      rd_data_s  = 1'b0;
      if (rd_en) begin
         case (raddr)
            ADDR_DATA: begin
               rd_data_s = 1'b1;
               if (rx_empty_s) begin
                  rdata_s = 32'h0000_0000;
               end else begin
                  rdata_s = {24'h00_0000, rx_mem_r[rx_rptr_r]};
               end
            end
            ADDR_STATUS: rdata_s = status_s;
            ADDR_CTRL:   rdata_s = {24'h00_0000, ctrl_r};
            ADDR_BAUD:   rdata_s = {16'h0000, baud_r};
`ifdef UART_REGFILE_IRQ_EN
            ADDR_INT_EN: rdata_s = {28'h000_0000, int_en_r};
`endif
            default:     raddrerr_s = 1'b1;
         endcase
      end else begin
         rdata_s = 32'h0000_0000;
      end
   end

   assign rdata    = rdata_s;
   assign rack     = rd_en;
   assign raddrerr = raddrerr_s;
   assign wack     = commit_s;
   assign waddrerr = wr_unmapped_s | tx_ovf_set_s;
   assign tx_valid = tx_valid_s;
   assign tx_data  = tx_empty_s ? 8'h00 : tx_mem_r[tx_rptr_r];
   assign cfg_ctrl = ctrl_r;
   assign cfg_baud = baud_r;

   // Delayed copy of wr_en for rising-edge detection.
   always_ff @(posedge pclk or negedge prst_n) begin
      if (!prst_n) wr_en_q_r <= 1'b0;
      else         wr_en_q_r <= wr_en;
   end

   // TX FIFO pointers and level.
   always_ff @(posedge pclk or negedge prst_n) begin
      if (!prst_n) begin
         tx_wptr_r  <= AW'(1'b0);
         tx_rptr_r  <= AW'(1'b0);
         tx_level_r <= ZERO_LVL;
      end else begin
         if (tx_push_s) tx_wptr_r <= tx_wptr_r + AW'(1'b1);
         if (tx_pop_s)  tx_rptr_r <= tx_rptr_r + AW'(1'b1);
         case ({tx_push_s, tx_pop_s})
            2'b10:   tx_level_r <= tx_level_r + LW'(1'b1);
            2'b01:   tx_level_r <= tx_level_r - LW'(1'b1);
            default: tx_level_r <= tx_level_r;
         endcase
      end
   end

   // RX FIFO pointers and level.
   always_ff @(posedge pclk or negedge prst_n) begin
      if (!prst_n) begin
         rx_wptr_r  <= AW'(1'b0);
         rx_rptr_r  <= AW'(1'b0);
         rx_level_r <= ZERO_LVL;
      end else begin
         if (rx_push_s) rx_wptr_r <= rx_wptr_r + AW'(1'b1);
         if (rx_pop_s)  rx_rptr_r <= rx_rptr_r + AW'(1'b1);
         case ({rx_push_s, rx_pop_s})
            2'b10:   rx_level_r <= rx_level_r + LW'(1'b1);
            2'b01:   rx_level_r <= rx_level_r - LW'(1'b1);
            default: rx_level_r <= rx_level_r;
         endcase
      end
   end

   // FIFO storage; contents are don't-care until the level covers them.
   always_ff @(posedge pclk) begin
      if (tx_push_s) tx_mem_r[tx_wptr_r] <= wdata[7:0];
      if (rx_push_s) rx_mem_r[rx_wptr_r] <= rx_data;
   end

   // Sticky error flags; a new event in the same cycle beats a W1C clear.
   always_ff @(posedge pclk or negedge prst_n) begin
      if (!prst_n) begin
         tx_ovf_r <= 1'b0;
         rx_ovr_r <= 1'b0;
      end else begin
         if (tx_ovf_set_s)                tx_ovf_r <= 1'b1;
         else if (wr_status_s & wdata[5]) tx_ovf_r <= 1'b0;
         if (rx_ovr_set_s)                rx_ovr_r <= 1'b1;
         else if (wr_status_s & wdata[4]) rx_ovr_r <= 1'b0;
      end
   end

   // Configuration registers.
   always_ff @(posedge pclk or negedge prst_n) begin
      if (!prst_n) begin
         ctrl_r <= 8'h00;
         baud_r <= BAUD_RST;
      end else begin
         if (wr_ctrl_s) ctrl_r <= wdata[7:0];
         if (wr_baud_s) baud_r <= wdata[15:0];
      end
   end

`ifdef UART_REGFILE_IRQ_EN
   // Interrupt enables and the registered interrupt line.
   always_ff @(posedge pclk or negedge prst_n) begin
      if (!prst_n) begin
         int_en_r <= 4'h0;
         irq_r    <= 1'b0;
      end else begin
         if (wr_int_en_s) int_en_r <= wdata[3:0];
         irq_r <= |(int_en_r & {tx_ovf_r, rx_ovr_r, tx_empty_s, ~rx_empty_s});
      end
   end
   assign irq = irq_r;
`else
   assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_regfile.sv
// tb_uart_regfile: directed plus randomized bench for uart_regfile, checked every
// cycle against a queue-based model of the register map.
module tb_uart_regfile;
   localparam int DEPTH = 16;
`ifdef UART_REGFILE_IRQ_EN
   localparam bit IRQ_ON = 1'b1;
`else
   localparam bit IRQ_ON = 1'b0;
`endif

   logic        pclk = 1'b0;
   logic        prst_n;
   logic [11:0] waddr, raddr;
   logic [31:0] wdata, rdata;
   logic        wr_en, rd_en, rack, wack, raddrerr, waddrerr;
   logic [7:0]  tx_data, rx_data, cfg_ctrl;
   logic        tx_valid, tx_ready, rx_valid, irq;
   logic [15:0] cfg_baud;

   always #5 pclk = ~pclk;

   uart_regfile #(.DEPTH(DEPTH), .BAUD_RST(16'd27)) dut (
      .pclk(pclk), .prst_n(prst_n), .waddr(waddr), .wdata(wdata), .wr_en(wr_en),
      .raddr(raddr), .rd_en(rd_en), .rdata(rdata), .rack(rack), .wack(wack),
      .raddrerr(raddrerr), .waddrerr(waddrerr), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .cfg_ctrl(cfg_ctrl),
      .cfg_baud(cfg_baud), .irq(irq));

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // reference model
   logic [7:0]  tx_q[$];
   logic [7:0]  rx_q[$];
   logic        m_tx_ovf, m_rx_ovr, m_irq, m_wr_prev;
   logic [7:0]  m_ctrl;
   logic [15:0] m_baud;
   logic [3:0]  m_inten;

   bit          bg_en = 1'b0;
   int          wack_cnt = 0;
   logic        last_werr, last_rerr;
   logic [31:0] last_rdata;

   function automatic bit is_mapped(input logic [11:0] a);
      return (a == 12'h000) || (a == 12'h004) || (a == 12'h008) || (a == 12'h00C) ||
             (IRQ_ON && a == 12'h010);
   endfunction

   function automatic logic [31:0] model_status();
      logic [31:0] s;
      s = 32'h0;
      s[0] = (tx_q.size() == DEPTH);
      s[1] = (tx_q.size() == 0);
      s[2] = (rx_q.size() == DEPTH);
      s[3] = (rx_q.size() == 0);
      s[4] = m_rx_ovr;
      s[5] = m_tx_ovf;
      s[15:8]  = 8'(tx_q.size());
      s[23:16] = 8'(rx_q.size());
      return s;
   endfunction

   task automatic model_reset();
      tx_q.delete();
      rx_q.delete();
      m_tx_ovf = 1'b0; m_rx_ovr = 1'b0; m_irq = 1'b0; m_wr_prev = 1'b0;
      m_ctrl = 8'h00; m_baud = 16'd27; m_inten = 4'h0;
   endtask

   // One clock cycle: check all outputs mid-cycle, then advance the model.
   task automatic step();
      logic commit, tx_pop, rx_pop, irq_next, w1c_tx, w1c_rx, set_tx, set_rx;
      logic [31:0] exp_rd;
      int tsz, rsz;
      if (bg_en) begin
         rx_valid = ($urandom_range(0, 2) == 0);
         rx_data  = 8'($urandom);
         tx_ready = 1'($urandom_range(0, 1));
      end
      @(negedge pclk);
      tsz = tx_q.size();
      rsz = rx_q.size();
      commit = wr_en && !m_wr_prev;
      tx_pop = m_ctrl[0] && (tsz > 0) && tx_ready;
      rx_pop = rd_en && (raddr == 12'h000) && (rsz > 0);
      exp_rd = 32'h0;
      if (rd_en && is_mapped(raddr)) begin
         case (raddr)
            12'h000: exp_rd = (rsz > 0) ? {24'h0, rx_q[0]} : 32'h0;
            12'h004: exp_rd = model_status();
            12'h008: exp_rd = {24'h0, m_ctrl};
            12'h00C: exp_rd = {16'h0, m_baud};
            default: exp_rd = {28'h0, m_inten};
         endcase
      end
      check_value("rack", rack, rd_en);
      check_value("rdata", rdata, exp_rd);
      check_value("raddrerr", raddrerr, rd_en && !is_mapped(raddr));
      check_value("wack", wack, commit);
      check_value("waddrerr", waddrerr,
                  commit && (!is_mapped(waddr) || (waddr == 12'h000 && tsz == DEPTH && !tx_pop)));
      check_value("tx_valid", tx_valid, m_ctrl[0] && tsz > 0);
      if (tsz > 0) check_value("tx_data", tx_data, tx_q[0]);
      check_value("cfg_ctrl", cfg_ctrl, m_ctrl);
      check_value("cfg_baud", cfg_baud, m_baud);
      check_value("irq", irq, m_irq);
      if (wack) begin
         wack_cnt++;
         last_werr = waddrerr;
      end
      if (rd_en) begin
         last_rdata = rdata;
         last_rerr  = raddrerr;
      end
      // next state
      irq_next = IRQ_ON && |(m_inten & {m_tx_ovf, m_rx_ovr, tsz == 0, rsz != 0});
      set_tx = 1'b0; set_rx = 1'b0; w1c_tx = 1'b0; w1c_rx = 1'b0;
      if (tx_pop) void'(tx_q.pop_front());
      if (rx_pop) void'(rx_q.pop_front());
      if (commit && is_mapped(waddr)) begin
         case (waddr)
            12'h000: begin
               if (tsz < DEPTH || tx_pop) tx_q.push_back(wdata[7:0]);
               else set_tx = 1'b1;
            end
            12'h004: begin
               w1c_tx = wdata[5];
               w1c_rx = wdata[4];
            end
            12'h008: m_ctrl = wdata[7:0];
            12'h00C: m_baud = wdata[15:0];
            default: m_inten = wdata[3:0];
         endcase
      end
      if (rx_valid && cfg_ctrl[1]) begin
         if (rsz < DEPTH || rx_pop) rx_q.push_back(rx_data);
         else set_rx = 1'b1;
      end
      m_tx_ovf  = (m_tx_ovf && !w1c_tx) || set_tx;
      m_rx_ovr  = (m_rx_ovr && !w1c_rx) || set_rx;
      m_irq     = irq_next;
      m_wr_prev = wr_en;
      @(posedge pclk);
      #1;
   endtask

   task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
      waddr = a; wdata = d; wr_en = 1'b1;
      step(); step();
      wr_en = 1'b0;
      step();
   endtask

   task automatic apb_read(input logic [11:0] a);
      raddr = a; rd_en = 1'b1;
      step();
      rd_en = 1'b0;
   endtask

   logic [11:0] addr_pool [8] = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h020, 12'h002, 12'h000};

   initial begin
      prst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
      waddr = 12'h0; wdata = 32'h0; raddr = 12'h0; rx_data = 8'h0;
      last_werr = 1'b0; last_rerr = 1'b0; last_rdata = 32'h0;
      model_reset();
      repeat (3) @(posedge pclk);
      #3 prst_n = 1'b1;
      @(posedge pclk);
      #1;

      // reset state
      check_value("rst_wack", wack, 32'h0);
      check_value("rst_irq", irq, 32'h0);
      check_value("rst_tx_valid", tx_valid, 32'h0);
      check_value("rst_tx_data", tx_data, 32'h0);
      check_value("rst_ctrl", cfg_ctrl, 32'h0);
      check_value("rst_baud", cfg_baud, 32'd27);
      check_value("rst_rdata", rdata, 32'h0);

      // single DATA write, wr_en held for two cycles
      apb_write(12'h008, 32'h03);
      wack_cnt = 0;
      apb_write(12'h000, 32'hA5);
      check_value("t1_wack_cnt", wack_cnt, 32'd1);
      check_value("t1_tx_valid", tx_valid, 32'h1);
      check_value("t1_tx_data", tx_data, 32'hA5);
      apb_read(12'h004);
      check_value("t1_status", last_rdata, 32'h0000_0108);

      // drain TX, then overfill RX
      tx_ready = 1'b1; step(); tx_ready = 1'b0;
      for (int i = 0; i < 17; i++) begin
         rx_valid = 1'b1; rx_data = 8'(i);
         step();
      end
      rx_valid = 1'b0;
      apb_read(12'h004);
      check_value("rx_full_status", last_rdata, 32'h0010_0016);
      for (int i = 0; i < 16; i++) begin
         apb_read(12'h000);
         check_value("rx_pop_byte", last_rdata, 32'(i));
      end
      apb_read(12'h000);
      check_value("rx_empty_read", last_rdata, 32'h0);
      apb_read(12'h004);
      check_value("rx_empty_status", last_rdata, 32'h0000_001A);
      apb_write(12'h004, 32'h10);
      apb_read(12'h004);
      check_value("rx_ovr_clear", last_rdata, 32'h0000_000A);

      // TX overflow, then a push accepted alongside a pop
      for (int i = 0; i < 16; i++) apb_write(12'h000, 32'(8'h30 + 8'(i)));
      last_werr = 1'b0;
      apb_write(12'h000, 32'hEE);
      check_value("tx_ovf_werr", last_werr, 32'h1);
      apb_read(12'h004);
      check_value("tx_ovf_status", last_rdata, 32'h0000_1029);
      waddr = 12'h000; wdata = 32'h77; wr_en = 1'b1; tx_ready = 1'b1;
      step();
      tx_ready = 1'b0;
      step();
      wr_en = 1'b0;
      step();
      check_value("tx_popfull_werr", last_werr, 32'h0);
      apb_read(12'h004);
      check_value("tx_popfull_status", last_rdata, 32'h0000_1029);
      apb_write(12'h004, 32'h20);

      // unmapped accesses
      apb_read(12'h020);
      check_value("unmapped_rerr", last_rerr, 32'h1);
      check_value("unmapped_rdata", last_rdata, 32'h0);
      apb_write(12'h002, 32'hFF);
      check_value("unmapped_werr", last_werr, 32'h1);
      apb_read(12'h004);
      check_value("unmapped_status", last_rdata, 32'h0000_1009);
      apb_read(12'h008);
      check_value("unmapped_ctrl", last_rdata, 32'h3);
      apb_read(12'h010);
      check_value("int_en_rerr", last_rerr, IRQ_ON ? 32'h0 : 32'h1);

      // rx_not_empty interrupt
      if (IRQ_ON) begin
         apb_write(12'h010, 32'h1);
         rx_valid = 1'b1; rx_data = 8'h5A;
         step();
         rx_valid = 1'b0;
         check_value("irq_after_push", irq, 32'h0);
         step();
         check_value("irq_high", irq, 32'h1);
         apb_read(12'h000);
         check_value("irq_at_pop", irq, 32'h1);
         step();
         check_value("irq_dropped", irq, 32'h0);
         apb_write(12'h010, 32'h0);
      end

      // reset in the middle of a write transfer
      waddr = 12'h000; wdata = 32'h3C; wr_en = 1'b1;
      step();
      prst_n = 1'b0;
      #2;
      model_reset();
      check_value("mid_rst_tx_valid", tx_valid, 32'h0);
      prst_n = 1'b1;
      wack_cnt = 0;
      step();
      wr_en = 1'b0;
      step();
      check_value("mid_rst_wack_cnt", wack_cnt, 32'd1);
      apb_read(12'h004);
      check_value("mid_rst_status", last_rdata, 32'h0000_0108);

      // randomized traffic
      apb_write(12'h008, 32'h03);
      bg_en = 1'b1;
      for (int i = 0; i < 500; i++) begin
         logic [11:0] a;
         logic [31:0] d;
         a = addr_pool[$urandom_range(0, 7)];
         d = $urandom;
         if (a == 12'h008) d[1:0] = 2'b11;
         case ($urandom_range(0, 3))
            0:       step();
            1:       apb_write(a, d);
            2:       apb_read(a);
            default: apb_write(12'h000, d);
         endcase
      end
      bg_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
